// File: rtl/ifu_pcgen.sv
`default_nettype none
// ============================================================================
//  Module   : ifu_pcgen
//  Purpose  : Fetch-side next-PC generator with a static branch predictor.
//             Owns the fetch PC, keeps at most one fetch outstanding, and
//             combines each fetch response with its predecode flags to form
//             the predicted next PC. The instruction, its PC and the
//             prediction are then pushed into the IFU->decode buffer.
//             An EXU misprediction redirect overrides everything. A response
//             that was already in flight when the redirect arrived is
//             drained and discarded.
//  Ports    : clk, rst_n            clock, synchronous active-low reset
//             ifu_req_*             fetch request (registered valid/pc)
//             ifu_rsp_*             fetch response (ready is combinational)
//             pd_*                  predecode of ifu_rsp_inst
//             rf_rd_idx/rf_rd_data  JALR base register read
//             dep_busy              pending write on rf_rd_idx
//             exu_redirect*         misprediction flush and corrected PC
//             ib_*                  registered instruction-buffer entry
//  Config   : ZCRV_BTFN_EN - when defined, conditional branches use
//             backward-taken / forward-not-taken prediction. Otherwise every
//             conditional branch is predicted not taken.
//  Revision : 1.0  initial release
// ============================================================================
module ifu_pcgen #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [31:0] ifu_req_pc,
    input  logic        ifu_rsp_valid,
    output logic        ifu_rsp_ready,
    input  logic [31:0] ifu_rsp_inst,
    input  logic        pd_op_jal,
    input  logic        pd_op_bxx,
    input  logic        pd_op_jalr,
    input  logic [31:0] pd_jump_imm,
    input  logic [4:0]  pd_rs1,
    output logic [4:0]  rf_rd_idx,
    input  logic [31:0] rf_rd_data,
    input  logic        dep_busy,
    input  logic        exu_redirect,
    input  logic [31:0] exu_redirect_pc,
    output logic        ib_valid,
    input  logic        ib_ready,
    output logic [31:0] ib_inst,
    output logic [31:0] ib_pc,
    output logic [31:0] ib_pred_pc,
    output logic        ib_pred_taken
);

    localparam logic [31:0] c_pc_step = 32'd4;

    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAIT_RSP = 2'd1,
        S_DROP     = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req_valid;
    logic [31:0] r_pc;
    logic        r_ib_valid;
    logic [31:0] r_ib_inst;
    logic [31:0] r_ib_pc;
    logic [31:0] r_ib_pred_pc;
    logic        r_ib_pred_taken;

    logic        w_slot_free;
    logic        w_jalr_stall;
    logic        w_rsp_ready;
    logic        w_load;
    logic        w_bxx_taken;
    logic [31:0] w_pc_seq;
    logic [31:0] w_br_tgt;
    logic [31:0] w_rs1_val;
    logic [31:0] w_jalr_tgt;
    logic [31:0] w_next_pc;
    logic        w_pred_taken;

    // The buffer slot can take a new entry if it is empty or drains this cycle.
    assign w_slot_free  = ~r_ib_valid | ib_ready;
    // A JALR cannot be predicted while its base register still has a write
    // in flight. x0 never has one.
    assign w_jalr_stall = pd_op_jalr & (pd_rs1 != 5'd0) & dep_busy;

    always_comb begin
        w_rsp_ready = 1'b0;
        if (exu_redirect) begin
            // Redirect swallows whatever response is presented.
            w_rsp_ready = 1'b1;
        end else begin
            case (r_state)
                S_WAIT_RSP: w_rsp_ready = w_slot_free & ~w_jalr_stall;
                S_DROP:     w_rsp_ready = 1'b1;
                default:    w_rsp_ready = 1'b0;
            endcase
        end
    end

    assign w_load = (r_state == S_WAIT_RSP) & ifu_rsp_valid & w_rsp_ready & ~exu_redirect;

`ifdef ZCRV_BTFN_EN
    // Backward (negative offset) branches are typically loops: predict taken.
    assign w_bxx_taken = pd_jump_imm[31];
`else
    assign w_bxx_taken = 1'b0;
`endif

    assign w_pc_seq   = r_pc + c_pc_step;
    assign w_br_tgt   = r_pc + pd_jump_imm;
    assign w_rs1_val  = (pd_rs1 == 5'd0) ? 32'd0 : rf_rd_data;
    assign w_jalr_tgt = (w_rs1_val + pd_jump_imm) & ~32'd1;

    always_comb begin
        w_next_pc = w_pc_seq;
        if (pd_op_jal) begin
            w_next_pc = w_br_tgt;
        end else if (pd_op_jalr) begin
            w_next_pc = w_jalr_tgt;
        end else if (pd_op_bxx && w_bxx_taken) begin
            w_next_pc = w_br_tgt;
        end
    end

    // "Taken" means any departure from sequential flow. A jump to pc+4 counts
    // as not taken.
    assign w_pred_taken = (w_next_pc != w_pc_seq);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_REQ;
            r_req_valid     <= 1'b1;
            r_pc            <= RESET_PC;
            r_ib_valid      <= 1'b0;
            r_ib_inst       <= 32'd0;
            r_ib_pc         <= 32'd0;
            r_ib_pred_pc    <= 32'd0;
            r_ib_pred_taken <= 1'b0;
        end else if (exu_redirect) begin
            r_pc       <= exu_redirect_pc;
            r_ib_valid <= 1'b0;
            case (r_state)
                S_REQ: begin
                    // A request accepted in the redirect cycle is stale; its
                    // response must be drained before fetching again.
                    if (ifu_req_ready) begin
                        r_state     <= S_DROP;
                        r_req_valid <= 1'b0;
                    end else begin
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                S_WAIT_RSP, S_DROP: begin
                    // The outstanding response is consumed now if present.
                    if (ifu_rsp_valid) begin
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                    end else begin
                        r_state     <= S_DROP;
                        r_req_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                end
            endcase
        end else begin
            if (w_load) begin
                r_ib_valid      <= 1'b1;
                r_ib_inst       <= ifu_rsp_inst;
                r_ib_pc         <= r_pc;
                r_ib_pred_pc    <= w_next_pc;
                r_ib_pred_taken <= w_pred_taken;
            end else if (ib_ready) begin
                r_ib_valid <= 1'b0;
            end

            case (r_state)
                S_REQ: begin
                    if (ifu_req_ready) begin
                        r_state     <= S_WAIT_RSP;
                        r_req_valid <= 1'b0;
                    end
                end
                S_WAIT_RSP: begin
                    if (w_load) begin
                        r_pc        <= w_next_pc;
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (ifu_rsp_valid) begin
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_REQ;
                    r_req_valid <= 1'b1;
                end
            endcase
        end
    end

    assign ifu_req_valid = r_req_valid;
    assign ifu_req_pc    = r_pc;
    assign ifu_rsp_ready = w_rsp_ready;
    assign rf_rd_idx     = pd_rs1;
    assign ib_valid      = r_ib_valid;
    assign ib_inst       = r_ib_inst;
    assign ib_pc         = r_ib_pc;
    assign ib_pred_pc    = r_ib_pred_pc;
    assign ib_pred_taken = r_ib_pred_taken;

endmodule
`default_nettype wire

// File: tb/tb_ifu_pcgen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ifu_pcgen
//  Purpose  : Self-checking bench for ifu_pcgen. It runs directed scenarios
//             with literal expectations, followed by randomized traffic
//             compared every cycle against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifu_pcgen;

`ifdef ZCRV_BTFN_EN
    localparam bit BTFN = 1'b1;
`else
    localparam bit BTFN = 1'b0;
`endif
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid = 1'b0;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_inst = 32'd0;
    logic        pd_op_jal = 1'b0;
    logic        pd_op_bxx = 1'b0;
    logic        pd_op_jalr = 1'b0;
    logic [31:0] pd_jump_imm = 32'd0;
    logic [4:0]  pd_rs1 = 5'd0;
    logic [4:0]  rf_rd_idx;
    logic [31:0] rf_rd_data = 32'd0;
    logic        dep_busy = 1'b0;
    logic        exu_redirect = 1'b0;
    logic [31:0] exu_redirect_pc = 32'd0;
    logic        ib_valid;
    logic        ib_ready = 1'b0;
    logic [31:0] ib_inst;
    logic [31:0] ib_pc;
    logic [31:0] ib_pred_pc;
    logic        ib_pred_taken;

    always #5 clk = ~clk;

    ifu_pcgen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ifu_req_valid   (ifu_req_valid),
        .ifu_req_ready   (ifu_req_ready),
        .ifu_req_pc      (ifu_req_pc),
        .ifu_rsp_valid   (ifu_rsp_valid),
        .ifu_rsp_ready   (ifu_rsp_ready),
        .ifu_rsp_inst    (ifu_rsp_inst),
        .pd_op_jal       (pd_op_jal),
        .pd_op_bxx       (pd_op_bxx),
        .pd_op_jalr      (pd_op_jalr),
        .pd_jump_imm     (pd_jump_imm),
        .pd_rs1          (pd_rs1),
        .rf_rd_idx       (rf_rd_idx),
        .rf_rd_data      (rf_rd_data),
        .dep_busy        (dep_busy),
        .exu_redirect    (exu_redirect),
        .exu_redirect_pc (exu_redirect_pc),
        .ib_valid        (ib_valid),
        .ib_ready        (ib_ready),
        .ib_inst         (ib_inst),
        .ib_pc           (ib_pc),
        .ib_pred_pc      (ib_pred_pc),
        .ib_pred_taken   (ib_pred_taken)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Knobs driven each cycle.
    bit          t_rst_n, t_req_ready, t_ib_ready, t_dep_busy, t_redir;
    logic [31:0] t_redir_pc;

    // Instruction currently presented by the memory and predecoder.
    logic [31:0] q_inst, q_imm, q_rf;
    bit          q_jal, q_bxx, q_jalr;
    logic [4:0]  q_rs1;
    int          lat;        // cycles until the outstanding response appears
    int          d_lat;      // latency used in directed mode
    bit          rand_mode;

    // Transaction-level model: is a fetch outstanding, is it to be discarded,
    // the PC to fetch next, and the contents of the single buffer entry.
    bit          m_known, m_out, m_drop, m_ibv, m_ib_tk;
    logic [31:0] m_pc, m_ib_inst, m_ib_pc, m_ib_pred;

    function automatic logic [31:0] predict(input logic [31:0] pc);
        logic [31:0] base;
        if (q_jal) return pc + q_imm;
        if (q_jalr) begin
            base = (q_rs1 == 5'd0) ? 32'd0 : q_rf;
            return (base + q_imm) & 32'hFFFF_FFFE;
        end
        if (q_bxx && BTFN && q_imm[31]) return pc + q_imm;
        return pc + 32'd4;
    endfunction

    task automatic set_rec(input bit jal, input bit bxx, input bit jalr,
                           input logic [31:0] imm, input logic [4:0] rs1,
                           input logic [31:0] rf);
        q_jal = jal; q_bxx = bxx; q_jalr = jalr;
        q_imm = imm; q_rs1 = rs1; q_rf = rf;
        q_inst = $urandom;
    endtask

    task automatic new_rec();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = int'($urandom_range(0, 5));
        q_jal = (k == 2); q_bxx = (k == 3); q_jalr = (k == 4);
        if (k == 5) begin
            q_jal  = 1'($urandom_range(0, 1));
            q_bxx  = 1'($urandom_range(0, 1));
            q_jalr = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 3) == 0) q_imm = r;
        else q_imm = {{20{r[11]}}, r[11:1], 1'b0};
        q_rs1  = q_jalr ? 5'($urandom_range(0, 31)) : 5'd0;
        q_rf   = $urandom;
        q_inst = $urandom;
    endtask

    task automatic start_fetch();
        if (rand_mode) begin
            new_rec();
            lat = int'($urandom_range(0, 3));
        end else begin
            lat = d_lat;
        end
    endtask

    // One clock: drive inputs, compare all outputs to the model, advance model.
    task automatic cycle();
        bit rsp_v, stall, slot, exp_rdy, req_fire, load;
        logic [31:0] nxt;
        @(negedge clk);
        rsp_v = m_out && (lat == 0);
        rst_n           = t_rst_n;
        ifu_req_ready   = t_req_ready;
        ifu_rsp_valid   = rsp_v;
        ifu_rsp_inst    = q_inst;
        pd_op_jal       = q_jal;
        pd_op_bxx       = q_bxx;
        pd_op_jalr      = q_jalr;
        pd_jump_imm     = q_imm;
        pd_rs1          = q_rs1;
        rf_rd_data      = q_rf;
        dep_busy        = t_dep_busy;
        exu_redirect    = t_redir;
        exu_redirect_pc = t_redir_pc;
        ib_ready        = t_ib_ready;
        #1;
        stall   = q_jalr && (q_rs1 != 5'd0) && t_dep_busy;
        slot    = !m_ibv || t_ib_ready;
        exp_rdy = t_redir || m_drop || (m_out && slot && !stall);
        if (t_rst_n && m_known) begin
            chk("req_valid",  32'(ifu_req_valid), 32'(!m_out));
            chk("req_pc",     ifu_req_pc, m_pc);
            chk("rsp_ready",  32'(ifu_rsp_ready), 32'(exp_rdy));
            chk("rf_rd_idx",  32'(rf_rd_idx), 32'(q_rs1));
            chk("ib_valid",   32'(ib_valid), 32'(m_ibv));
            chk("ib_inst",    ib_inst, m_ib_inst);
            chk("ib_pc",      ib_pc, m_ib_pc);
            chk("ib_pred_pc", ib_pred_pc, m_ib_pred);
            chk("ib_taken",   32'(ib_pred_taken), 32'(m_ib_tk));
        end
        // Advance the model to the state after this rising edge.
        if (m_out && !rsp_v && lat > 0) lat--;
        req_fire = !m_out && t_req_ready;
        if (!t_rst_n) begin
            m_known = 1; m_out = 0; m_drop = 0; m_pc = RESET_PC;
            m_ibv = 0; m_ib_inst = 0; m_ib_pc = 0; m_ib_pred = 0; m_ib_tk = 0;
        end else if (m_known) begin
            if (t_redir) begin
                m_pc  = t_redir_pc;
                m_ibv = 0;
                if (!m_out) begin
                    m_out  = req_fire;
                    m_drop = req_fire;
                    if (req_fire) start_fetch();
                end else if (rsp_v) begin
                    m_out = 0; m_drop = 0;
                end else begin
                    m_drop = 1;
                end
            end else begin
                load = m_out && !m_drop && rsp_v && exp_rdy;
                if (load) begin
                    nxt       = predict(m_pc);
                    m_ib_inst = q_inst;
                    m_ib_pc   = m_pc;
                    m_ib_pred = nxt;
                    m_ib_tk   = (nxt != m_pc + 32'd4);
                    m_ibv     = 1;
                    m_pc      = nxt;
                    m_out     = 0;
                end else begin
                    if (t_ib_ready) m_ibv = 0;
                    if (req_fire) begin
                        m_out = 1;
                        start_fetch();
                    end else if (m_drop && rsp_v) begin
                        m_out = 0; m_drop = 0;
                    end
                end
            end
        end
    endtask

    // Observe registered outputs just after the next rising edge.
    task automatic peek();
        @(posedge clk);
        #2;
    endtask

    // Move the fetch PC with a redirect while no fetch is outstanding.
    task automatic set_pc(input logic [31:0] pc);
        t_redir = 1; t_redir_pc = pc; t_req_ready = 0;
        cycle();
        t_redir = 0; t_req_ready = 1;
    endtask

    initial begin
        m_known = 0; m_out = 0; m_drop = 0; m_ibv = 0; m_ib_tk = 0;
        m_pc = 0; m_ib_inst = 0; m_ib_pc = 0; m_ib_pred = 0;
        lat = 0; d_lat = 0; rand_mode = 0;
        t_req_ready = 1; t_ib_ready = 1; t_dep_busy = 0; t_redir = 0; t_redir_pc = 0;
        set_rec(0, 0, 0, 32'd0, 5'd0, 32'd0);

        // Reset state.
        t_rst_n = 0;
        cycle();
        cycle();
        t_rst_n = 1;
        peek();
        chk("lit_rst_req_valid", 32'(ifu_req_valid), 32'd1);
        chk("lit_rst_req_pc", ifu_req_pc, 32'h8000_0000);
        chk("lit_rst_ib_valid", 32'(ib_valid), 32'd0);
        chk("lit_rst_ib_pc", ib_pc, 32'd0);

        // Sequential instruction.
        cycle();
        cycle();
        peek();
        chk("lit_seq_ib_valid", 32'(ib_valid), 32'd1);
        chk("lit_seq_ib_pc", ib_pc, 32'h8000_0000);
        chk("lit_seq_pred", ib_pred_pc, 32'h8000_0004);
        chk("lit_seq_taken", 32'(ib_pred_taken), 32'd0);
        chk("lit_seq_req_pc", ifu_req_pc, 32'h8000_0004);

        // JAL backwards.
        set_pc(32'h8000_0010);
        set_rec(1, 0, 0, 32'hFFFF_FFF0, 5'd0, 32'd0);
        cycle();
        cycle();
        peek();
        chk("lit_jal_pred", ib_pred_pc, 32'h8000_0000);
        chk("lit_jal_taken", 32'(ib_pred_taken), 32'd1);
        chk("lit_jal_req_pc", ifu_req_pc, 32'h8000_0000);

        // Backward conditional branch.
        set_pc(32'h0000_0100);
        set_rec(0, 1, 0, 32'hFFFF_FFF8, 5'd0, 32'd0);
        cycle();
        cycle();
        peek();
        chk("lit_bxx_back_pred", ib_pred_pc, BTFN ? 32'h0000_00F8 : 32'h0000_0104);
        chk("lit_bxx_back_taken", 32'(ib_pred_taken), BTFN ? 32'd1 : 32'd0);

        // Forward conditional branch.
        set_pc(32'h0000_0100);
        set_rec(0, 1, 0, 32'h0000_0008, 5'd0, 32'd0);
        cycle();
        cycle();
        peek();
        chk("lit_bxx_fwd_pred", ib_pred_pc, 32'h0000_0104);
        chk("lit_bxx_fwd_taken", 32'(ib_pred_taken), 32'd0);

        // JALR stalled by a pending write to its base register.
        set_pc(32'h0000_0300);
        set_rec(0, 0, 1, 32'd3, 5'd5, 32'h0000_0200);
        t_dep_busy = 1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lit_jalr_stall_rdy", 32'(ifu_rsp_ready), 32'd0);
        end
        t_dep_busy = 0;
        cycle();
        chk("lit_jalr_go_rdy", 32'(ifu_rsp_ready), 32'd1);
        peek();
        chk("lit_jalr_pred", ib_pred_pc, 32'h0000_0202);
        chk("lit_jalr_taken", 32'(ib_pred_taken), 32'd1);
        chk("lit_jalr_ib_pc", ib_pc, 32'h0000_0300);

        // Redirect while waiting for a response that shows up two cycles later.
        set_pc(32'h0000_0500);
        set_rec(0, 0, 0, 32'd0, 5'd0, 32'd0);
        d_lat = 2;
        cycle();
        t_redir = 1; t_redir_pc = 32'h0000_0400;
        cycle();
        t_redir = 0;
        cycle();
        chk("lit_drop_req_valid", 32'(ifu_req_valid), 32'd0);
        cycle();
        chk("lit_drop_rsp_ready", 32'(ifu_rsp_ready), 32'd1);
        peek();
        chk("lit_redir_req_valid", 32'(ifu_req_valid), 32'd1);
        chk("lit_redir_req_pc", ifu_req_pc, 32'h0000_0400);
        chk("lit_redir_ib_valid", 32'(ib_valid), 32'd0);
        d_lat = 0;

        // Buffer back-pressure: second response must wait for the slot.
        t_ib_ready = 0;
        cycle();
        cycle();
        cycle();
        cycle();
        chk("lit_bp_rsp_ready0", 32'(ifu_rsp_ready), 32'd0);
        cycle();
        chk("lit_bp_rsp_ready1", 32'(ifu_rsp_ready), 32'd0);
        t_ib_ready = 1;
        cycle();
        chk("lit_bp_rsp_ready2", 32'(ifu_rsp_ready), 32'd1);
        peek();
        chk("lit_bp_ib_pc", ib_pc, 32'h0000_0404);
        chk("lit_bp_ib_valid", 32'(ib_valid), 32'd1);

        // Randomized traffic against the model.
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            t_rst_n     = (i != 2000);
            t_req_ready = ($urandom_range(0, 3) != 0);
            t_ib_ready  = ($urandom_range(0, 9) < 7);
            t_dep_busy  = ($urandom_range(0, 9) < 3);
            t_redir     = ($urandom_range(0, 24) == 0);
            t_redir_pc  = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_pcgen.md
# ifu_pcgen

Fetch-side next-PC generator and static branch predictor. It owns the PC register and issues one-outstanding fetch requests. It consumes the fetch response together with that instruction's predecode flags (jal/bxx/jalr, sign-extended immediate, rs1), computes the predicted next PC, and pushes the instruction plus its prediction into the instruction buffer. It sits between the fetch memory port, the combinational predecoder and the IFU→decode buffer, and accepts EXU misprediction redirects.

## Interface
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ifu_req_valid  out  1  fetch request valid
- ifu_req_ready  in  1  memory accepts request
- ifu_req_pc  out  32  fetch address
- ifu_rsp_valid  in  1  instruction word valid
- ifu_rsp_ready  out  1  response accepted
- ifu_rsp_inst  in  32  instruction word (also drives predecoder)
- pd_op_jal / pd_op_bxx / pd_op_jalr  in  1 each  predecode flags for ifu_rsp_inst
- pd_jump_imm  in  32  sign-extended branch/jump immediate
- pd_rs1  in  5  JALR base register index (0 when not JALR)
- rf_rd_idx  out  5  register-file read index (= pd_rs1)
- rf_rd_data  in  32  combinational read data
- dep_busy  in  1  rf_rd_idx has a pending write (scoreboard)
- exu_redirect  in  1  misprediction flush
- exu_redirect_pc  in  32  corrected PC
- ib_valid  out  1  buffer entry valid
- ib_ready  in  1  buffer accepts entry
- ib_inst / ib_pc / ib_pred_pc  out  32 each  instruction, its PC, predicted next PC
- ib_pred_taken  out  1  prediction differs from pc+4

## Operation
- States: REQ, WAIT_RSP, DROP. Reset: state REQ, pc=RESET_PC, ib_valid=0, ib_* data=0.
- REQ: ifu_req_valid=1, ifu_req_pc=pc; on ifu_req_ready → WAIT_RSP.
- WAIT_RSP: ifu_rsp_ready = slot_free & ~jalr_stall, where slot_free = ~ib_valid | ib_ready and jalr_stall = pd_op_jalr & (pd_rs1≠0) & dep_busy. On handshake: ib regs load {inst, pc, next, taken}, ib_valid=1, pc<=next → REQ.
- next PC (32-bit, wrap mod 2^32): JAL: pc+imm; BXX predicted taken: pc+imm, else pc+4; JALR: (rs1val+imm)&~1, rs1val=0 when pd_rs1=0 else rf_rd_data; otherwise pc+4. Priority jal > jalr > bxx. taken = (next ≠ pc+4).
- ib_valid clears on ib_ready when no new load the same cycle.
- exu_redirect (highest priority, any state): pc<=exu_redirect_pc; ib_valid<=0; ifu_rsp_ready forced 1, response discarded. Next state: REQ→DROP if request handshake this cycle else REQ; WAIT_RSP→REQ if ifu_rsp_valid this cycle else DROP; DROP→DROP unless ifu_rsp_valid.
- DROP: ifu_req_valid=0, ifu_rsp_ready=1, response discarded, no ib load; on ifu_rsp_valid → REQ.
- Reset mid-operation: returns to reset values next edge; in-flight response after reset is not guarded.

## Timing
- ifu_req_* and ib_* are registered; ifu_rsp_ready and rf_rd_idx are combinational.
- Minimum 2 cycles per instruction (REQ, WAIT_RSP); ib entry visible the cycle after the response handshake.
- Redirect to request: exu_redirect in cycle N → ifu_req_valid with new PC at N+1 (no outstanding fetch) or after stale response drains.
- ifu_req_valid stays high with stable pc until ifu_req_ready.

## Configuration
- ZCRV_BTFN_EN defined: BXX predicted taken when pd_jump_imm[31]=1 (backward), not taken otherwise.
- Undefined: every BXX predicted not taken (next=pc+4, taken=0); JAL/JALR unchanged.

## Test plan
- Reset, all ready: first ifu_req_pc=0x8000_0000; sequential non-branch → 0x8000_0004, ib_pred_taken=0.
- JAL at 0x8000_0010, imm=-16 → ib_pred_pc=0x8000_0000, taken=1, next req 0x8000_0000.
- BXX at 0x100, imm=-8: with ZCRV_BTFN_EN pred 0xF8; without, 0x104; imm=+8 → 0x104 both.
- JALR rs1=5, imm=3, rf_rd_data=0x200, dep_busy high 3 cycles → rsp_ready low 3 cycles, then pred_pc=0x202.
- Redirect to 0x400 while in WAIT_RSP, response arrives 2 cycles later → response dropped, ib_valid stays 0, next req 0x400.
- ib_ready low with entry held + new response → rsp_ready=0 until ib_ready; no entry lost or duplicated.
